rf_wr_arbiter: RTL and testbench

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_wr_arbiter.sv | 101 ++++++++++
 tb/tb_rf_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter driving a register-file write port, with burst lock and clear.
//   clk_i, rst_ni           : clock (rising edge) and asynchronous active-low reset
//   req_valid_i/req_lock_i  : per-requester write valid and burst-lock request
//   req_addr_i/req_data_i   : packed per-requester address/data, requester i at slice i
//   req_ready_o             : per-requester grant, one-hot or zero
//   clr_req_i/clr_ack_o     : register-file clear request (level) and one-cycle acknowledge
//   rf_wr_*_o, rf_clr_o     : registered register-file write/clear drive
//   busy_o                  : arbiter is in LOCK or CLEAR
module rf_wr_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumRegs = 32,
  parameter int NumReq = 4,
  localparam int AddrWidth = $clog2(NumRegs),
  localparam int ReqWidth = $clog2(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  input  logic [NumReq-1:0]              req_lock_i,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq*DataWidth-1:0]    req_data_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic                           clr_req_i,
  output logic                           clr_ack_o,
  output logic                           rf_wr_en_o,
  output logic [AddrWidth-1:0]           rf_wr_addr_o,
  output logic [DataWidth-1:0]           rf_wr_data_o,
  output logic                           rf_clr_o,
  output logic                           busy_o
);
  typedef enum logic [1:0] {IDLE, LOCK, CLEAR} state_e;
  state_e state_q, state_d;
  logic [ReqWidth-1:0] last_q, last_d, owner_q, owner_d, rr_idx, gnt_idx, cand;
  logic rr_found, hs, lock_hs;
  logic wr_en_q, wr_en_d, clr_q, clr_d;
  logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [DataWidth-1:0] wr_data_q, wr_data_d;
  logic [AddrWidth-1:0] addr_a [NumReq];
  logic [DataWidth-1:0] data_a [NumReq];
  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_a[g] = req_addr_i[g*AddrWidth +: AddrWidth];
    assign data_a[g] = req_data_i[g*DataWidth +: DataWidth];
  end
  // Round-robin search starting just after the last granted requester, with wrap.
  always_comb begin
    rr_idx = '0;
    rr_found = 1'b0;
    cand = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = ReqWidth'((int'(last_q) + k) % NumReq);
      if (!rr_found && req_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx = cand;
      end
    end
  end
  always_comb begin
    gnt_idx = state_q == LOCK ? owner_q : rr_idx;
    req_ready_o = !rst_ni ? '0
                : (state_q == IDLE && !clr_req_i && rr_found) ? NumReq'(1) << rr_idx
                : state_q == LOCK ? NumReq'(req_valid_i[owner_q]) << owner_q
                : '0;
    hs = |(req_ready_o & req_valid_i);
    lock_hs = hs && req_lock_i[gnt_idx];
    state_d = state_q == IDLE ? (clr_req_i ? CLEAR : lock_hs ? LOCK : IDLE)
            : state_q == LOCK ? ((hs && !req_lock_i[owner_q]) ? IDLE : LOCK)
            : IDLE;
    owner_d = (state_q == IDLE && lock_hs) ? gnt_idx : owner_q;
    last_d = hs ? gnt_idx : last_q;
    wr_en_d = hs;
    wr_addr_d = hs ? addr_a[gnt_idx] : wr_addr_q;
    wr_data_d = hs ? data_a[gnt_idx] : wr_data_q;
    clr_d = state_q == IDLE && clr_req_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q <= ReqWidth'(NumReq - 1);
      owner_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      clr_q <= clr_d;
    end
  end
  assign rf_wr_en_o = wr_en_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_wr_data_o = wr_data_q;
  // The clear pulse and its acknowledge coincide with the single CLEAR-state cycle.
  assign rf_clr_o = clr_q;
  assign clr_ack_o = clr_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed and random scoreboard bench for rf_wr_arbiter.
module tb_rf_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NR-1:0] req_valid_i = '0, req_lock_i = '0, req_ready_o;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_data_i;
  logic clr_req_i = 1'b0, clr_ack_o, rf_wr_en_o, rf_clr_o, busy_o;
  logic [AW-1:0] rf_wr_addr_o;
  logic [DW-1:0] rf_wr_data_o;
  logic [AW-1:0] a_addr [NR];
  logic [DW-1:0] a_data [NR];
  int errors = 0, checks = 0;
  int m_state = 0;
  logic [1:0] m_last = 2'd3, m_owner = 2'd0, g, c;
  logic m_clr = 1'b0, exp_wr;
  logic [NR-1:0] exp_ready;
  logic [AW+DW-1:0] sb [$];
  logic [AW+DW-1:0] w;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] rf_ref [32];
  logic [DW-1:0] rf_dut [32];
  rf_wr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_lock_i(req_lock_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .clr_req_i(clr_req_i), .clr_ack_o(clr_ack_o), .rf_wr_en_o(rf_wr_en_o),
    .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o), .rf_clr_o(rf_clr_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always_comb begin
    req_addr_i = '0;
    req_data_i = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr_i[i*AW +: AW] = a_addr[i];
      req_data_i[i*DW +: DW] = a_data[i];
    end
  end
  // Reference model: checks registered outputs against the scoreboard, then predicts this cycle's grant.
  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_state = 0;
      m_last = 2'd3;
      m_owner = 2'd0;
      m_clr = 1'b0;
      sb.delete();
      hold_addr = '0;
      hold_data = '0;
    end else begin
      exp_wr = sb.size() > 0;
      if (exp_wr) begin
        w = sb.pop_front();
        hold_addr = w[AW+DW-1:DW];
        hold_data = w[DW-1:0];
      end
      checks++;
      if (rf_wr_en_o !== exp_wr) begin errors++; $display("FAIL sb_wr_en t=%0t got %b exp %b", $time, rf_wr_en_o, exp_wr); end
      checks++;
      if (rf_wr_addr_o !== hold_addr || rf_wr_data_o !== hold_data) begin
        errors++; $display("FAIL sb_wr_data t=%0t got %h/%h exp %h/%h", $time, rf_wr_addr_o, rf_wr_data_o, hold_addr, hold_data);
      end
      checks++;
      if (rf_clr_o !== m_clr || clr_ack_o !== m_clr) begin errors++; $display("FAIL sb_clr t=%0t got %b/%b exp %b", $time, rf_clr_o, clr_ack_o, m_clr); end
      checks++;
      if (busy_o !== (m_state != 0)) begin errors++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy_o, m_state != 0); end
      checks++;
      if (!$onehot0(req_ready_o) || (rf_clr_o && rf_wr_en_o)) begin
        errors++; $display("FAIL sb_exclusive t=%0t ready %b clr %b wr %b", $time, req_ready_o, rf_clr_o, rf_wr_en_o);
      end
      if (rf_clr_o) for (int i = 0; i < 32; i++) rf_dut[i] = '0;
      if (rf_wr_en_o) rf_dut[rf_wr_addr_o] = rf_wr_data_o;
      if (m_clr) for (int i = 0; i < 32; i++) rf_ref[i] = '0;
      if (exp_wr) rf_ref[hold_addr] = hold_data;
      exp_ready = '0;
      g = 2'd0;
      if (m_state == 0 && !clr_req_i) begin
        for (int k = 1; k <= NR; k++) begin
          c = 2'((int'(m_last) + k) % NR);
          if (exp_ready == '0 && req_valid_i[c]) begin exp_ready[c] = 1'b1; g = c; end
        end
      end else if (m_state == 1) begin
        g = m_owner;
        exp_ready[g] = req_valid_i[g];
      end
      checks++;
      if (req_ready_o !== exp_ready) begin errors++; $display("FAIL sb_ready t=%0t got %b exp %b", $time, req_ready_o, exp_ready); end
      m_clr = 1'b0;
      if (exp_ready != '0) begin
        sb.push_back({a_addr[g], a_data[g]});
        m_last = g;
      end
      case (m_state)
        0: if (clr_req_i) begin m_state = 2; m_clr = 1'b1; end
           else if (exp_ready != '0 && req_lock_i[g]) begin m_state = 1; m_owner = g; end
        1: if (exp_ready != '0 && !req_lock_i[g]) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready_o); end
    checks++;
    if ({rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rf_clr_o, clr_ack_o, busy_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b %h %h %b %b %b exp all zero", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rf_clr_o, clr_ack_o, busy_o);
    end
    req_valid_i = '0;
    rst_ni = 1'b1;
  endtask
  task automatic test_round_robin();
    for (int i = 0; i < NR; i++) begin a_addr[i] = 5'(i + 1); a_data[i] = 32'hA5A5_0000 + i; end
    req_valid_i = 4'hF;
    for (int k = 0; k < NR; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready_o !== 4'(1 << k)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, req_ready_o, 4'(1 << k)); end
      if (k > 0) begin
        checks++;
        if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'(k)) begin errors++; $display("FAIL rr_write%0d got %b/%h exp 1/%h", k, rf_wr_en_o, rf_wr_addr_o, 5'(k)); end
      end
      next();
    end
    req_valid_i = '0;
    @(negedge clk);
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd4 || rf_wr_data_o !== 32'hA5A5_0003) begin
      errors++; $display("FAIL rr_last_write got %b/%h/%h exp 1/04/a5a50003", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o);
    end
    next();
  endtask
  task automatic test_lock();
    for (int n = 0; n < 4; n++) begin
      req_valid_i = n == 0 ? 4'b0100 : 4'b0110;
      req_lock_i = n == 3 ? 4'b0000 : 4'b0100;
      a_data[2] = 32'hC0DE_0000 + n;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL lock_grant%0d got %b exp 0100", n, req_ready_o); end
      if (n == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL lock_busy got %b exp 1", busy_o); end
      end
      next();
    end
    req_valid_i = 4'b0010;
    req_lock_i = '0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 4'b0010 || busy_o !== 1'b0) begin errors++; $display("FAIL lock_release got %b/%b exp 0010/0", req_ready_o, busy_o); end
    next();
    req_valid_i = '0;
    next();
  endtask
  task automatic test_clear();
    req_valid_i = 4'b0001;
    clr_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 4'b0) begin errors++; $display("FAIL clr_req_ready got %b exp 0000", req_ready_o); end
    next();
    clr_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_clr_o, clr_ack_o, rf_wr_en_o, busy_o} !== 4'b1101 || req_ready_o !== 4'b0) begin
      errors++; $display("FAIL clr_cycle got clr/ack/wr/busy %b%b%b%b ready %b exp 1101/0000", rf_clr_o, clr_ack_o, rf_wr_en_o, busy_o, req_ready_o);
    end
    next();
    @(negedge clk);
    checks++;
    if (req_ready_o !== 4'b0001 || rf_clr_o !== 1'b0) begin errors++; $display("FAIL clr_after got %b/%b exp 0001/0", req_ready_o, rf_clr_o); end
    next();
  endtask
  task automatic test_clear_in_lock();
    for (int n = 0; n < 3; n++) begin
      req_valid_i = 4'b0010;
      req_lock_i = n == 2 ? 4'b0000 : 4'b0010;
      clr_req_i = n > 0;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 4'b0010 || rf_clr_o !== 1'b0) begin errors++; $display("FAIL clrlock_owner%0d got %b/%b exp 0010/0", n, req_ready_o, rf_clr_o); end
      next();
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== 4'b0 || rf_clr_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL clrlock_defer got %b/%b/%b exp 0000/0/0", req_ready_o, rf_clr_o, busy_o);
    end
    next();
    clr_req_i = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    checks++;
    if (rf_clr_o !== 1'b1 || clr_ack_o !== 1'b1) begin errors++; $display("FAIL clrlock_clear got %b/%b exp 1/1", rf_clr_o, clr_ack_o); end
    next();
  endtask
  task automatic test_reset_in_lock();
    req_valid_i = 4'b1000;
    req_lock_i = 4'b1000;
    a_data[3] = 32'hDEAD_BEEF;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL rstlock_grant%0d got %b exp 1000", n, req_ready_o); end
      next();
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rf_clr_o, clr_ack_o, busy_o} !== '0 || req_ready_o !== 4'b0) begin
      errors++; $display("FAIL rstlock_abort got wr %b addr %h data %h busy %b ready %b exp all zero", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, busy_o, req_ready_o);
    end
    #1;
    rst_ni = 1'b1;
    req_valid_i = 4'hF;
    req_lock_i = '0;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rstlock_first got %b exp 0001", req_ready_o); end
    next();
    req_valid_i = '0;
    next();
  endtask
  task automatic test_random();
    int bad;
    for (int n = 0; n < 10000; n++) begin
      req_valid_i = 4'($urandom);
      req_lock_i = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0;
      clr_req_i = $urandom_range(0, 19) == 0;
      for (int i = 0; i < NR; i++) begin a_addr[i] = 5'($urandom); a_data[i] = $urandom; end
      next();
    end
    req_valid_i = '0;
    req_lock_i = '0;
    clr_req_i = 1'b0;
    repeat (3) next();
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf_dut[i] !== rf_ref[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_rf_contents got %0d differing registers exp 0", bad); end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin rf_ref[i] = '0; rf_dut[i] = '0; end
    for (int i = 0; i < NR; i++) begin a_addr[i] = '0; a_data[i] = '0; end
    test_reset();
    test_round_robin();
    test_lock();
    test_clear();
    test_clear_in_lock();
    test_reset_in_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
